// File: rtl/mac_if_pkg.sv
// Shared GMII receive constants, default frame-length limits and the RX frame sequencer state type.
package mac_if_pkg;

  localparam int GMII_DATA_W = 8;

  localparam logic [GMII_DATA_W-1:0] ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [GMII_DATA_W-1:0] ETH_SFD_BYTE      = 8'hD5;

  localparam int DEFAULT_MIN_FRAME_LEN = 64;
  localparam int DEFAULT_MAX_FRAME_LEN = 1522;
  localparam int DEFAULT_LEN_W         = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_DROP
  } rx_frame_state_e;

endpackage

// File: rtl/gmii_rx_frame_ctrl_if.sv
// GMII byte stream in, delimited frame stream out. Statistics counters exist only when
// GMII_RX_STATS_EN is defined.
interface gmii_rx_frame_ctrl_if;
  import mac_if_pkg::*;

  logic [GMII_DATA_W-1:0] gmii_data;
  logic                   gmii_valid;
  logic                   gmii_error;

  logic [GMII_DATA_W-1:0] data;
  logic                   valid;
  logic                   sof;
  logic                   eof;
  logic                   err;

`ifdef GMII_RX_STATS_EN
  logic [31:0] good_frames;
  logic [31:0] bad_frames;
  logic [31:0] drop_events;

  modport master (
    output gmii_data, gmii_valid, gmii_error,
    input  data, valid, sof, eof, err, good_frames, bad_frames, drop_events
  );
  modport slave (
    input  gmii_data, gmii_valid, gmii_error,
    output data, valid, sof, eof, err, good_frames, bad_frames, drop_events
  );
`else
  modport master (
    output gmii_data, gmii_valid, gmii_error,
    input  data, valid, sof, eof, err
  );
  modport slave (
    input  gmii_data, gmii_valid, gmii_error,
    output data, valid, sof, eof, err
  );
`endif

endinterface

// File: rtl/gmii_rx_frame_ctrl.sv
// Strips preamble/SFD from the GMII byte stream and emits delimited frames with a one-byte hold
// so eof lands on the last byte. Optional frame statistics under GMII_RX_STATS_EN.
module gmii_rx_frame_ctrl
  import mac_if_pkg::*;
#(
  parameter int MIN_FRAME_LEN = DEFAULT_MIN_FRAME_LEN,
  parameter int MAX_FRAME_LEN = DEFAULT_MAX_FRAME_LEN,
  parameter int LEN_W         = DEFAULT_LEN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  gmii_rx_frame_ctrl_if.slave  bus
);

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_FRAME_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_LEN);

  rx_frame_state_e        state_reg, state_next;
  logic [LEN_W-1:0]       count_reg, count_next;
  logic [GMII_DATA_W-1:0] hold_reg, hold_next;
  logic                   first_reg, first_next;
  logic                   sticky_reg, sticky_next;

  logic [GMII_DATA_W-1:0] data_reg, data_next;
  logic                   valid_reg, valid_next;
  logic                   sof_reg, sof_next;
  logic                   eof_reg, eof_next;
  logic                   err_reg, err_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      hold_reg   <= '0;
      first_reg  <= 1'b0;
      sticky_reg <= 1'b0;
      data_reg   <= '0;
      valid_reg  <= 1'b0;
      sof_reg    <= 1'b0;
      eof_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      hold_reg   <= hold_next;
      first_reg  <= first_next;
      sticky_reg <= sticky_next;
      data_reg   <= data_next;
      valid_reg  <= valid_next;
      sof_reg    <= sof_next;
      eof_reg    <= eof_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    hold_next   = hold_reg;
    first_next  = first_reg;
    sticky_next = sticky_reg;
    data_next   = hold_reg;
    valid_next  = 1'b0;
    sof_next    = 1'b0;
    eof_next    = 1'b0;
    err_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        count_next  = '0;
        sticky_next = 1'b0;
        if (bus.gmii_valid) begin
          if (!bus.gmii_error && bus.gmii_data == ETH_PREAMBLE_BYTE) state_next = ST_PREAMBLE;
          else                                                       state_next = ST_DROP;
        end
      end

      ST_PREAMBLE: begin
        if (!bus.gmii_valid) begin
          state_next = ST_IDLE;
        end else if (bus.gmii_error) begin
          state_next = ST_DROP;
        end else if (bus.gmii_data == ETH_SFD_BYTE) begin
          state_next = ST_PAYLOAD;
          first_next = 1'b1;
          count_next = '0;
        end else if (bus.gmii_data != ETH_PREAMBLE_BYTE) begin
          state_next = ST_DROP;
        end
      end

      ST_PAYLOAD: begin
        // count_reg is the number of bytes accepted so far, including the one in hold_reg
        if (!bus.gmii_valid) begin
          state_next = ST_IDLE;
          if (count_reg != '0) begin
            valid_next = 1'b1;
            sof_next   = first_reg;
            eof_next   = 1'b1;
            err_next   = sticky_reg || (count_reg < MIN_LEN);
          end
        end else if (count_reg >= MAX_LEN) begin
          state_next = ST_DROP;
          valid_next = 1'b1;
          sof_next   = first_reg;
          eof_next   = 1'b1;
          err_next   = 1'b1;
        end else begin
          hold_next   = bus.gmii_data;
          count_next  = (count_reg == '1) ? count_reg : count_reg + LEN_W'(1);
          sticky_next = sticky_reg || bus.gmii_error;
          if (count_reg != '0) begin
            valid_next = 1'b1;
            sof_next   = first_reg;
            first_next = 1'b0;
          end
        end
      end

      ST_DROP: begin
        if (!bus.gmii_valid) state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.data  = data_reg;
  assign bus.valid = valid_reg;
  assign bus.sof   = sof_reg;
  assign bus.eof   = eof_reg;
  assign bus.err   = err_reg;

`ifdef GMII_RX_STATS_EN
  // Index 0: good frames, 1: bad frames, 2: entries into DROP from IDLE/PREAMBLE
  logic [2:0]       stat_inc;
  logic [2:0][31:0] stat_cnt;

  assign stat_inc[0] = valid_reg && eof_reg && !err_reg;
  assign stat_inc[1] = valid_reg && eof_reg && err_reg;
  assign stat_inc[2] = (state_next == ST_DROP) &&
                       (state_reg == ST_IDLE || state_reg == ST_PREAMBLE);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_stat
      logic [31:0] cnt_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                cnt_reg <= '0;
        else if (stat_inc[gi] && cnt_reg != '1) cnt_reg <= cnt_reg + 32'd1;
      end
      assign stat_cnt[gi] = cnt_reg;
    end
  endgenerate

  assign bus.good_frames = stat_cnt[0];
  assign bus.bad_frames  = stat_cnt[1];
  assign bus.drop_events = stat_cnt[2];
`endif

endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// Self-checking bench for gmii_rx_frame_ctrl: scenario tasks against a burst-level frame model.
`timescale 1ns/1ps
module tb_gmii_rx_frame_ctrl;
  import mac_if_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic       err;
  } ev_t;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1522;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;

  gmii_rx_frame_ctrl_if bus();

  gmii_rx_frame_ctrl #(
    .MIN_FRAME_LEN (MIN_LEN),
    .MAX_FRAME_LEN (MAX_LEN),
    .LEN_W         (11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus: one entry per clock (byte, valid, error) plus the edge count when it was applied
  logic [7:0] sd[$];
  bit         sv[$];
  bit         se[$];
  int         sc[$];
  ev_t        dut_q[$];
  ev_t        exp_q[$];
  int         dq_cyc[$];

  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      ev_t e;
      e.d   = bus.data;
      e.sof = bus.sof;
      e.eof = bus.eof;
      e.err = bus.eof ? bus.err : 1'b0;
      dut_q.push_back(e);
      dq_cyc.push_back(cyc);
      if (bus.eof === 1'b1)
        $display("[TB] frame out: last=%02h err=%b at cycle %0d", bus.data, bus.err, cyc);
    end
  end

  task automatic clear_stim();
    sd.delete(); sv.delete(); se.delete(); sc.delete();
  endtask

  task automatic push_byte(logic [7:0] d, bit v, bit e);
    sd.push_back(d); sv.push_back(v); se.push_back(e);
  endtask

  task automatic add_idle(int n);
    for (int k = 0; k < n; k++) push_byte(8'h00, 1'b0, 1'b0);
  endtask

  // npre preamble bytes, a delimiter byte, len payload bytes, then one idle cycle
  task automatic add_frame(int npre, logic [7:0] sfd, int len, int err_at, bit incr);
    for (int k = 0; k < npre; k++) push_byte(8'h55, 1'b1, 1'b0);
    push_byte(sfd, 1'b1, 1'b0);
    for (int k = 0; k < len; k++)
      push_byte(incr ? 8'(k) : 8'($urandom_range(0, 255)), 1'b1, k == err_at);
    add_idle(1);
  endtask

  task automatic step(logic [7:0] d, bit v, bit e);
    bus.gmii_data  = d;
    bus.gmii_valid = v;
    bus.gmii_error = e;
    @(posedge clk);
    #1;
  endtask

  // Reference: split the stimulus into valid bursts; a burst is a frame only if it is
  // one or more clean 0x55 then a clean 0xD5. Payload beyond MAX_LEN is cut off.
  task automatic build_expected();
    int i;
    exp_q.delete();
    i = 0;
    while (i < sd.size()) begin
      if (!sv[i]) begin
        i++;
      end else begin
        int  j, p, start, len, keep;
        bit  bad;
        ev_t e;
        j = i;
        while (j < sd.size() && sv[j]) j++;
        p = i;
        while (p < j && sd[p] == 8'h55 && !se[p]) p++;
        if (p > i && p < j && sd[p] == 8'hD5 && !se[p]) begin
          start = p + 1;
          len   = j - start;
          keep  = (len > MAX_LEN) ? MAX_LEN : len;
          bad   = (len < MIN_LEN) || (len > MAX_LEN);
          for (int k = 0; k < keep; k++) if (se[start + k]) bad = 1'b1;
          for (int k = 0; k < keep; k++) begin
            e.d   = sd[start + k];
            e.sof = (k == 0);
            e.eof = (k == keep - 1);
            e.err = (k == keep - 1) ? bad : 1'b0;
            exp_q.push_back(e);
          end
        end
        i = j;
      end
    end
  endtask

  task automatic run_stim();
    dut_q.delete();
    dq_cyc.delete();
    sc.delete();
    for (int i = 0; i < sd.size(); i++) begin
      sc.push_back(cyc);
      step(sd[i], sv[i], se[i]);
    end
    repeat (4) step(8'h00, 1'b0, 1'b0);
    build_expected();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.gmii_data  = 8'h00;
    bus.gmii_valid = 1'b0;
    bus.gmii_error = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({bus.data, bus.valid, bus.sof, bus.eof, bus.err} !== 12'h000) begin
      failed++;
      $display("FAIL reset_outputs: got %03h want 000",
               {bus.data, bus.valid, bus.sof, bus.eof, bus.err});
    end
    rst = 1'b0;
    step(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_good_frame();
    clear_stim();
    add_frame(7, 8'hD5, 64, -1, 1'b1);
    run_stim();
    tests++;
    if (dut_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL good_frame count: got %0d want %0d", dut_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < dut_q.size(); i++) begin
      tests++;
      if (dut_q[i] !== exp_q[i]) begin
        failed++;
        $display("FAIL good_frame[%0d]: got %h want %h", i, dut_q[i], exp_q[i]);
      end
    end
    if (dut_q.size() == 64) begin
      // payload byte 0 is stimulus index 8; valid falls at index 72
      tests++;
      if (dq_cyc[0] - sc[8] != 2) begin
        failed++;
        $display("FAIL first_latency: got %0d want 2", dq_cyc[0] - sc[8]);
      end
      tests++;
      if (dq_cyc[63] - sc[72] != 1) begin
        failed++;
        $display("FAIL last_latency: got %0d want 1", dq_cyc[63] - sc[72]);
      end
    end
  endtask

  task automatic test_runt();
    clear_stim();
    add_frame(7, 8'hD5, 60, -1, 1'b0);
    add_frame(1, 8'hD5, 1, -1, 1'b0);
    add_frame(2, 8'hD5, 63, -1, 1'b0);
    add_frame(0, 8'hD5, 10, -1, 1'b0);
    run_stim();
    tests++;
    if (dut_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL runt count: got %0d want %0d", dut_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < dut_q.size(); i++) begin
      tests++;
      if (dut_q[i] !== exp_q[i]) begin
        failed++;
        $display("FAIL runt[%0d]: got %h want %h", i, dut_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_rx_error();
    clear_stim();
    add_frame(7, 8'hD5, 100, 49, 1'b0);
    add_frame(7, 8'hD5, 64, -1, 1'b0);
    run_stim();
    tests++;
    if (dut_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL rx_error count: got %0d want %0d", dut_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < dut_q.size(); i++) begin
      tests++;
      if (dut_q[i] !== exp_q[i]) begin
        failed++;
        $display("FAIL rx_error[%0d]: got %h want %h", i, dut_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_oversize();
    clear_stim();
    add_frame(7, 8'hD5, 1530, -1, 1'b0);
    add_frame(3, 8'hD5, 70, -1, 1'b0);
    run_stim();
    tests++;
    if (dut_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL oversize count: got %0d want %0d", dut_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < dut_q.size(); i++) begin
      tests++;
      if (dut_q[i] !== exp_q[i]) begin
        failed++;
        $display("FAIL oversize[%0d]: got %h want %h", i, dut_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_stim();
    add_frame(3, 8'h12, 20, -1, 1'b0);
    add_frame(7, 8'hD5, 64, -1, 1'b0);
    push_byte(8'h55, 1'b1, 1'b0);
    push_byte(8'h55, 1'b1, 1'b1);
    push_byte(8'hD5, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++) push_byte(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    add_idle(1);
    add_frame(5, 8'hD5, 65, -1, 1'b0);
    run_stim();
    tests++;
    if (dut_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL back_to_back count: got %0d want %0d", dut_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < dut_q.size(); i++) begin
      tests++;
      if (dut_q[i] !== exp_q[i]) begin
        failed++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i, dut_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_payload();
    int eofs;
    clear_stim();
    dut_q.delete();
    for (int k = 0; k < 7; k++) step(8'h55, 1'b1, 1'b0);
    step(8'hD5, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++) step(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.data, bus.valid, bus.sof, bus.eof, bus.err} !== 12'h000) begin
      failed++;
      $display("FAIL mid_reset_outputs: got %03h want 000",
               {bus.data, bus.valid, bus.sof, bus.eof, bus.err});
    end
    bus.gmii_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(8'h00, 1'b0, 1'b0);
    eofs = 0;
    foreach (dut_q[i]) if (dut_q[i].eof) eofs++;
    tests++;
    if (eofs != 0) begin
      failed++;
      $display("FAIL mid_reset_eof: got %0d eof want 0", eofs);
    end
    add_frame(7, 8'hD5, 64, -1, 1'b0);
    run_stim();
    tests++;
    if (dut_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL after_reset count: got %0d want %0d", dut_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < dut_q.size(); i++) begin
      tests++;
      if (dut_q[i] !== exp_q[i]) begin
        failed++;
        $display("FAIL after_reset[%0d]: got %h want %h", i, dut_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    clear_stim();
    repeat (16) begin
      int r, len, npre, err_at;
      r      = $urandom_range(0, 9);
      len    = (r < 3) ? MIN_LEN - 1 + $urandom_range(0, 2) : $urandom_range(1, 120);
      npre   = $urandom_range((r == 9) ? 0 : 1, 7);
      err_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
      add_frame(npre, (r == 8) ? 8'h5D : 8'hD5, len, err_at, 1'b0);
      add_idle($urandom_range(0, 2));
    end
    run_stim();
    tests++;
    if (dut_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL random count: got %0d want %0d", dut_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < dut_q.size(); i++) begin
      tests++;
      if (dut_q[i] !== exp_q[i]) begin
        failed++;
        $display("FAIL random[%0d]: got %h want %h", i, dut_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_runt();
    test_rx_error();
    test_oversize();
    test_back_to_back();
    test_reset_mid_payload();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
